// File: rtl/fibo_bus_ctrl.sv
// Sequencing controller for the shared-bus Fibonacci datapath (R0, R1, T, adder S).
// Optional overflow abort is enabled by defining FIBO_CTRL_OVF_STOP_EN.
module fibo_bus_ctrl #(
   parameter int CNT_W = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [CNT_W-1:0] n_steps,
   input  logic             carry,
   output logic [2:0]       oe,
   output logic [2:0]       ld,
   output logic             clr,
   output logic             term,
   output logic             busy,
   output logic             done,
   output logic             ovf,
   output logic [CNT_W-1:0] step_cnt
);

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      INIT   = 3'd1,
      SUM    = 3'd2,
      MOVE   = 3'd3,
      COMMIT = 3'd4,
      FIN    = 3'd5
   } state_t;

   state_t           state;
   state_t           nxt;
   logic [CNT_W-1:0] n_lat;
   logic [2:0]       ld_q;
   logic             ovf_q;
   logic             abort;

`ifdef FIBO_CTRL_OVF_STOP_EN
   assign abort = (state == SUM) && carry;
`else
   logic unused_carry;
   assign unused_carry = carry;
   assign abort = 1'b0;
`endif

   always_comb begin
      nxt = state;
      case (state)
         IDLE:    nxt = start ? INIT : IDLE;
         INIT:    nxt = (n_lat == '0) ? FIN : SUM;
         SUM:     nxt = abort ? FIN : MOVE;
         MOVE:    nxt = COMMIT;
         COMMIT:  nxt = ((step_cnt + CNT_W'(1)) == n_lat) ? FIN : SUM;
         FIN:     nxt = IDLE;
         default: nxt = IDLE;
      endcase
   end

   // Outputs are registered from the next state so they change only at clock edges.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state    <= IDLE;
         n_lat    <= '0;
         oe       <= 3'b010;
         ld_q     <= 3'b000;
         clr      <= 1'b0;
         term     <= 1'b0;
         busy     <= 1'b0;
         done     <= 1'b0;
         ovf_q    <= 1'b0;
         step_cnt <= '0;
      end else begin
         state <= nxt;
         if (state == IDLE && start) begin
            n_lat    <= n_steps;
            step_cnt <= '0;
            ovf_q    <= 1'b0;
         end else if (state == COMMIT) begin
            step_cnt <= step_cnt + CNT_W'(1);
         end
         if (abort) ovf_q <= 1'b1;

         oe   <= 3'b010;
         ld_q <= 3'b000;
         clr  <= 1'b0;
         term <= 1'b0;
         busy <= 1'b0;
         done <= 1'b0;
         case (nxt)
            INIT: begin
               clr  <= 1'b1;
               busy <= 1'b1;
            end
            SUM: begin
               oe   <= 3'b001;
               ld_q <= 3'b100;
               busy <= 1'b1;
            end
            MOVE: begin
               ld_q <= 3'b001;
               busy <= 1'b1;
            end
            COMMIT: begin
               oe   <= 3'b100;
               ld_q <= 3'b010;
               term <= 1'b1;
               busy <= 1'b1;
            end
            FIN:     done <= 1'b1;
            default: ;
         endcase
      end
   end

   // A carried sum must not reach T, so the SUM load is suppressed in the same cycle.
   assign ld = abort ? 3'b000 : ld_q;

`ifdef FIBO_CTRL_OVF_STOP_EN
   assign ovf = ovf_q;
`else
   logic unused_ovf;
   assign unused_ovf = ovf_q;
   assign ovf = 1'b0;
`endif

endmodule

// File: tb/tb_fibo_bus_ctrl.sv
// Self-checking bench for fibo_bus_ctrl: timing-formula model plus a modelled 32-bit datapath.
// Honours FIBO_CTRL_OVF_STOP_EN when it is defined for the build.
module tb_fibo_bus_ctrl;
   localparam int CNT_W = 8;
   localparam int P_IDLE = 0, P_INIT = 1, P_SUM = 2, P_MOVE = 3, P_COMMIT = 4, P_FIN = 5;

   logic             clk = 1'b0;
   logic             rst, start, carry;
   logic [CNT_W-1:0] n_steps;
   logic [2:0]       oe, ld;
   logic             clr, term, busy, done, ovf;
   logic [CNT_W-1:0] step_cnt;

   logic [31:0] r0 = '0, r1 = '0, t = '0, pre_a = '0, pre_b = 32'd1, bus;
   logic [32:0] sum33;

   int n_total = 0, n_pass = 0;
   int cyc = 0, k = 0, run_n = 0, abort_i = 0, committed = 0;
   bit run_valid = 1'b0;
   logic [31:0] terms [0:255];
   logic [31:0] init_b = 32'd1;
   logic [31:0] obs [$];
   int term_cnt = 0, clr_cnt = 0, done_off = -1;
   logic [31:0] fib5 [5] = '{32'd1, 32'd2, 32'd3, 32'd5, 32'd8};

   always #5 clk = ~clk;

   fibo_bus_ctrl #(.CNT_W(CNT_W)) dut (
      .clk(clk), .rst(rst), .start(start), .n_steps(n_steps), .carry(carry),
      .oe(oe), .ld(ld), .clr(clr), .term(term), .busy(busy), .done(done),
      .ovf(ovf), .step_cnt(step_cnt)
   );

   // Datapath model: tri-state bus as a mux, adder, and three registers.
   assign sum33 = {1'b0, r0} + {1'b0, r1};
   assign carry = sum33[32];
   always_comb begin
      bus = '0;
      if (oe[0]) bus = sum33[31:0];
      else if (oe[1]) bus = r1;
      else if (oe[2]) bus = t;
   end
   always @(posedge clk) begin
      if (clr) begin
         r0 <= pre_a;
         r1 <= pre_b;
      end else begin
         if (ld[2]) t <= bus;
         if (ld[0]) r0 <= bus;
         if (ld[1]) r1 <= bus;
      end
   end

   task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
      n_total++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h at t=%0t", name, got, exp, $time);
   endtask

   // Phase of cycle o after the start edge, from the published timing rules.
   function automatic int phase_of(input int o);
      int last;
      if (!run_valid || o < 1) return P_IDLE;
      if (o == 1) return P_INIT;
      last = (abort_i != 0) ? 3 * abort_i : 3 * run_n + 2;
      if (o == last) return P_FIN;
      if (o > last) return P_IDLE;
      case ((o - 2) % 3)
         0:       return P_SUM;
         1:       return P_MOVE;
         default: return P_COMMIT;
      endcase
   endfunction

   always @(posedge clk) begin
      logic [32:0] s;
      logic [31:0] a, b;
      if (!rst && start === 1'b1 && phase_of(cyc - k) == P_IDLE) begin
         k = cyc;
         run_n = int'(n_steps);
         abort_i = 0;
         init_b = pre_b;
         a = pre_a;
         b = pre_b;
         for (int i = 1; i <= run_n; i++) begin
            s = {1'b0, a} + {1'b0, b};
`ifdef FIBO_CTRL_OVF_STOP_EN
            if (s[32]) begin
               abort_i = i;
               break;
            end
`endif
            terms[i] = s[31:0];
            a = b;
            b = s[31:0];
         end
         committed = (abort_i != 0) ? abort_i - 1 : run_n;
         run_valid = 1'b1;
      end
      cyc = cyc + 1;
   end

   always @(negedge clk) begin
      int o, ph, cnt;
      logic [2:0] e_oe, e_ld;
      logic e_clr, e_term, e_busy, e_done, e_ovf;
      o = cyc - k;
      ph = phase_of(o);
      e_oe = 3'b010; e_ld = 3'b000; e_clr = 0; e_term = 0; e_busy = 0; e_done = 0;
      case (ph)
         P_INIT: begin e_clr = 1; e_busy = 1; end
         P_SUM: begin
            e_oe = 3'b001; e_busy = 1;
            e_ld = (abort_i != 0 && o == 3 * abort_i - 1) ? 3'b000 : 3'b100;
         end
         P_MOVE:   begin e_ld = 3'b001; e_busy = 1; end
         P_COMMIT: begin e_oe = 3'b100; e_ld = 3'b010; e_term = 1; e_busy = 1; end
         P_FIN:    e_done = 1;
         default: ;
      endcase
      cnt = (!run_valid || o < 2) ? 0 : (o - 2) / 3;
      if (cnt > committed) cnt = committed;
      e_ovf = run_valid && abort_i != 0 && o >= 3 * abort_i;
      check("outputs", {oe, ld, clr, term, busy, done, ovf, step_cnt},
            {e_oe, e_ld, e_clr, e_term, e_busy, e_done, e_ovf, CNT_W'(cnt)});
      check("oe_onehot", ($countones(oe) <= 1), 1);
      if (ph == P_COMMIT) begin
         check("commit_bus", bus, terms[(o - 1) / 3]);
         obs.push_back(bus);
      end
      if (ph == P_FIN) check("fin_r1", bus, (committed > 0) ? terms[committed] : init_b);
      if (term) term_cnt++;
      if (clr) clr_cnt++;
      if (done) done_off = o;
   end

   task automatic launch(input int n, input logic [31:0] a, input logic [31:0] b);
      pre_a = a;
      pre_b = b;
      obs.delete();
      term_cnt = 0;
      clr_cnt = 0;
      done_off = -1;
      @(negedge clk);
      start = 1'b1;
      n_steps = CNT_W'(n);
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic wait_done(input int budget);
      bit seen;
      seen = 0;
      for (int i = 0; i < budget && !seen; i++) begin
         @(negedge clk);
         if (done === 1'b1) seen = 1;
      end
      check("done_timeout", seen, 1);
   endtask

   initial begin
      bit found;
      rst = 1'b1;
      start = 1'b0;
      n_steps = '0;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      repeat (5) @(negedge clk);
      check("rst_oe", oe, 3'b010);
      check("rst_ld", ld, 3'b000);
      check("rst_busy_done", {busy, done}, 2'b00);
      check("rst_step_cnt", step_cnt, 0);

      // Five terms from the standard init.
      launch(5, 32'd0, 32'd1);
      wait_done(40);
      @(negedge clk);
      for (int i = 0; i < 5; i++) begin
         check("model_fib5", terms[i + 1], fib5[i]);
         check("n5_bus", obs[i], fib5[i]);
      end
      check("n5_obs_size", obs.size(), 5);
      check("n5_terms", term_cnt, 5);
      check("n5_done_at", done_off, 17);
      check("n5_step_cnt", step_cnt, 5);

      // Zero terms: INIT straight to FIN.
      launch(0, 32'd0, 32'd1);
      wait_done(10);
      @(negedge clk);
      check("n0_done_at", done_off, 2);
      check("n0_clr_cycles", clr_cnt, 1);
      check("n0_terms", term_cnt, 0);
      check("n0_r1_parked", bus, 32'd1);

      // start while busy and in FIN must be ignored.
      launch(4, 32'd0, 32'd1);
      repeat (3) @(negedge clk);
      start = 1'b1;
      n_steps = 8'd7;
      @(negedge clk);
      start = 1'b0;
      n_steps = 8'd4;
      wait_done(30);
      start = 1'b1;
      n_steps = 8'd9;
      @(negedge clk);
      start = 1'b0;
      check("ign_busy", busy, 1'b0);
      check("ign_terms", term_cnt, 4);
      check("ign_step_cnt", step_cnt, 4);
      check("ign_done_at", done_off, 14);
      @(negedge clk);

      // Asynchronous reset in the middle of the second MOVE.
      launch(10, 32'd0, 32'd1);
      found = 0;
      for (int i = 0; i < 40 && !found; i++) begin
         @(negedge clk);
         if (phase_of(cyc - k) == P_MOVE && (cyc - k) > 4) found = 1;
      end
      check("move_reached", found, 1);
      #2;
      rst = 1'b1;
      run_valid = 1'b0;
      #1;
      check("arst_oe_ld", {oe, ld}, 6'b010_000);
      check("arst_flags", {clr, term, busy, done, ovf}, 5'b0);
      check("arst_step_cnt", step_cnt, 0);
      @(negedge clk);
      rst = 1'b0;
      launch(3, 32'd0, 32'd1);
      wait_done(20);
      @(negedge clk);
      check("n3_obs_size", obs.size(), 3);
      for (int i = 0; i < 3; i++) check("n3_bus", obs[i], fib5[i]);

      // Datapath preloaded so the second sum carries out of 32 bits.
      launch(50, 32'h7000_0000, 32'h8000_0000);
      wait_done(200);
      @(negedge clk);
      check("ovf_t1", obs[0], 32'hF000_0000);
`ifdef FIBO_CTRL_OVF_STOP_EN
      check("ovf_flag", ovf, 1'b1);
      check("ovf_step_cnt", step_cnt, 1);
      check("ovf_done_at", done_off, 6);
      check("ovf_r1_held", r1, 32'hF000_0000);
`else
      check("wrap_t2", obs[1], 32'h7000_0000);
      check("wrap_ovf", ovf, 1'b0);
      check("wrap_step_cnt", step_cnt, 50);
      check("wrap_done_at", done_off, 152);
`endif
      repeat (2) @(negedge clk);
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end
endmodule
